// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_ctrl.
// The datapath is the master: it reports hazards and consumes stall/flush controls.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  modport master (
    output id_rs1,
    output id_rs2,
    output ex_rd,
    output ex_mem_read,
    output ex_branch_taken,
    output mem_req,
    output mem_ack,
    input  pc_write,
    input  if_id_write,
    input  if_id_flush,
    input  id_ex_flush,
    input  mem_stall,
    input  stall_cnt,
    input  mem_timeout
  );

  modport slave (
    input  id_rs1,
    input  id_rs2,
    input  ex_rd,
    input  ex_mem_read,
    input  ex_branch_taken,
    input  mem_req,
    input  mem_ack,
    output pc_write,
    output if_id_write,
    output if_id_flush,
    output id_ex_flush,
    output mem_stall,
    output stall_cnt,
    output mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use bubble,
// memory timeout detection and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave ctl
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [7:0]       wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q;

  logic load_use;
  logic mem_wait;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;
  logic mem_stall;

  assign load_use = ctl.ex_mem_read && (ctl.ex_rd != 5'd0) &&
                    ((ctl.ex_rd == ctl.id_rs1) || (ctl.ex_rd == ctl.id_rs2));
  assign mem_wait = ctl.mem_req && !ctl.mem_ack;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_stall   = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        if (mem_wait) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          mem_stall   = 1'b1;
          state_d     = MEM_WAIT;
          wait_d      = 8'd1;
        end else if (ctl.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            rem_d   = FLUSH_RELOAD;
          end
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      (state_q == FLUSH): begin
        if (mem_wait) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          mem_stall   = 1'b1;
          state_d     = MEM_WAIT;
          wait_d      = 8'd1;
          rem_d       = 3'd0;
        end else begin
          // ID holds a bubble here, so load-use cannot occur
          if_id_flush = 1'b1;
          if (ctl.ex_branch_taken) begin
            id_ex_flush = 1'b1;
            rem_d       = FLUSH_RELOAD;
          end else begin
            rem_d = rem_q - 3'd1;
            if (rem_q <= 3'd1) begin
              rem_d   = 3'd0;
              state_d = RUN;
            end
          end
        end
      end
      (state_q == MEM_WAIT): begin
        if (ctl.mem_ack) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q >= WAIT_MAX) begin
          tmo_d   = 1'b1;
          state_d = RUN;
          wait_d  = 8'd0;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          mem_stall   = 1'b1;
          wait_d      = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        rem_d   = 3'd0;
        wait_d  = 8'd0;
      end
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      mem_stall   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
      wait_q  <= 8'd0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      if (!pc_write && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ctl.pc_write    = pc_write;
  assign ctl.if_id_write = if_id_write;
  assign ctl.if_id_flush = if_id_flush;
  assign ctl.id_ex_flush = id_ex_flush;
  assign ctl.mem_stall   = mem_stall;
  assign ctl.stall_cnt   = cnt_q;
  assign ctl.mem_timeout = tmo_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: one instance with a 2-cycle
// flush and short timeout, one default instance with a 4-bit stall counter.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) a_if ();
  pipeline_ctrl_if #(.CNT_W(4))  b_if ();

  pipeline_ctrl #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (16)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (a_if.slave)
  );

  pipeline_ctrl #(
    .CNT_W(4)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (b_if.slave)
  );

  assign b_if.id_rs1          = a_if.id_rs1;
  assign b_if.id_rs2          = a_if.id_rs2;
  assign b_if.ex_rd           = a_if.ex_rd;
  assign b_if.ex_mem_read     = a_if.ex_mem_read;
  assign b_if.ex_branch_taken = a_if.ex_branch_taken;
  assign b_if.mem_req         = a_if.mem_req;
  assign b_if.mem_ack         = a_if.mem_ack;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, mem_stall}
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] LU  = 5'b00010;
  localparam logic [4:0] BR  = 5'b11110;
  localparam logic [4:0] FL  = 5'b11100;
  localparam logic [4:0] MS  = 5'b00001;
  localparam logic [4:0] RST = 5'b00110;

  typedef struct packed {
    logic [4:0]  o;
    logic [15:0] cnt;
    logic        tmo;
  } exp_t;

  exp_t        q[$];
  string       tq[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] mcnt = '0;

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr,
                        input logic br, input logic req, input logic ack);
    a_if.id_rs1          = rs1;
    a_if.id_rs2          = rs2;
    a_if.ex_rd           = rd;
    a_if.ex_mem_read     = mr;
    a_if.ex_branch_taken = br;
    a_if.mem_req         = req;
    a_if.mem_ack         = ack;
  endtask

  task automatic step(input string tag, input logic [4:0] o,
                      input logic tmo);
    exp_t  e;
    exp_t  g;
    string t;
    e.o   = o;
    e.cnt = mcnt;
    e.tmo = tmo;
    q.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
    e = q.pop_front();
    t = tq.pop_front();
    g.o   = {a_if.pc_write, a_if.if_id_write, a_if.if_id_flush,
             a_if.id_ex_flush, a_if.mem_stall};
    g.cnt = a_if.stall_cnt;
    g.tmo = a_if.mem_timeout;
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s: got o=%b cnt=%0d tmo=%b, expected o=%b cnt=%0d tmo=%b",
             t, g.o, g.cnt, g.tmo, e.o, e.cnt, e.tmo);
    end
    if (!rst_n) mcnt = '0;
    else if (!e.o[4]) mcnt = mcnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset0", RST, 1'b0);
    step("reset1", RST, 1'b0);
    rst_n = 1'b1;
    step("idle", DEF, 1'b0);

    set_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs2", LU, 1'b0);
    set_in(5'd1, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_done", DEF, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rd0", DEF, 1'b0);
    set_in(5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rs1", LU, 1'b0);
    set_in(5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step("no_memread", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("br_c0", BR, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_c1", FL, 1'b0);
    step("br_c2", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("br2_c0", BR, 1'b0);
    step("br2_in_flush", BR, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br2_reload", FL, 1'b0);
    step("br2_done", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("brlu_c0", BR, 1'b0);
    set_in(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_suppressed", FL, 1'b0);
    step("lu_after_flush", LU, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("brlu_done", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw_c0", MS, 1'b0);
    step("mw_c1", MS, 1'b0);
    step("mw_c2", MS, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mw_ack", DEF, 1'b0);
    step("req_ack_run", DEF, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mw_done", DEF, 1'b0);

    set_in(5'd2, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    step("sim_freeze", MS, 1'b0);
    set_in(5'd2, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    step("sim_ack", DEF, 1'b0);
    set_in(5'd2, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    step("sim_branch", BR, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sim_flush", FL, 1'b0);
    step("sim_done", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("flmw_br", BR, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("flmw_freeze", MS, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("flmw_ack", DEF, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("flmw_no_residual", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("tmo_w1", MS, 1'b0);
    step("tmo_w2", MS, 1'b0);
    step("tmo_w3", MS, 1'b0);
    step("tmo_w4", MS, 1'b0);
    step("tmo_release", DEF, 1'b0);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tmo_set", DEF, 1'b1);
    set_in(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("tmo_sticky_lu", LU, 1'b1);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("tmo_sticky", DEF, 1'b1);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rmw_c0", MS, 1'b1);
    step("rmw_c1", MS, 1'b1);
    rst_n = 1'b0;
    step("rmw_rst0", RST, 1'b1);
    step("rmw_rst1", RST, 1'b0);
    rst_n = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rmw_release", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rfl_br", BR, 1'b0);
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rfl_rst", RST, 1'b0);
    rst_n = 1'b1;
    step("rfl_release", DEF, 1'b0);

    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    tests++;
    assert (b_if.stall_cnt === 4'd14) else begin
      fails++;
      $error("FAIL sat_cnt14: got %0d expected 14", b_if.stall_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    tests++;
    assert (b_if.stall_cnt === 4'hF) else begin
      fails++;
      $error("FAIL sat_cnt15: got %0d expected 15", b_if.stall_cnt);
    end
    tests++;
    assert (b_if.mem_stall === 1'b1) else begin
      fails++;
      $error("FAIL sat_still_waiting: got %b expected 1", b_if.mem_stall);
    end
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
